assertion_event_logger: RTL and testbench

Downstream consumer of the 32-bit checker vector produced by the baked-in assertion block. It detects newly fired checkers and keeps a sticky fired-checker summary and a saturating event counter. It queues each firing with its PC in a small show-ahead FIFO for software or debug readout. When a configurable event threshold is reached, it raises a recovery request to the exception/debug unit using a req/ack handshake.

---
 rtl/assertion_event_logger.sv | 132 +++++++++++++
 tb/tb_assertion_event_logger.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/assertion_event_logger.sv
// Logs rising checker firings into a show-ahead FIFO, tracks a sticky summary and a saturating event count,
// and raises a req/ack recovery alarm at a count threshold. Define OR1200_ASSERT_LOG_TIMESTAMP_EN for per-entry cycle stamps.
module assertion_event_logger #(
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16,
  parameter int THRESH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [31:0]      checkers_fired,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      chk_mask,
  input  logic             rd_en,
  input  logic             clear,
  input  logic             alarm_ack,
  output logic [31:0]      sticky,
  output logic [CNT_W-1:0] event_count,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic             overflow,
  output logic [31:0]      rd_pc,
  output logic [31:0]      rd_mask,
  output logic [15:0]      rd_stamp,
  output logic             alarm_req
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_CLR} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  state_t           state;
  logic [31:0]      prev;
  logic [31:0]      new_bits;
  logic [31:0]      sticky_next;
  logic             evt;
  logic             pop;
  logic             do_push;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_next;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      mask_mem [DEPTH];

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A same-cycle clear acts first, so a coincident event starts the new epoch.
  always_comb begin
    new_bits    = checkers_fired & ~prev & chk_mask;
    evt         = enable && (|new_bits);
    pop         = rd_en && !fifo_empty;
    do_push     = evt && (!fifo_full || pop);
    cnt_base    = clear ? '0 : event_count;
    cnt_next    = evt ? sat_inc(cnt_base) : cnt_base;
    sticky_next = (clear ? 32'h0 : sticky) | (evt ? new_bits : 32'h0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev        <= '0;
      sticky      <= '0;
      event_count <= '0;
      overflow    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      state       <= IDLE;
      alarm_req   <= 1'b0;
    end else begin
      if (enable) prev <= checkers_fired;
      sticky      <= sticky_next;
      event_count <= cnt_next;
      overflow    <= (overflow && !clear) || (evt && fifo_full && !pop);
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case (state)
        IDLE: if (evt && (cnt_next >= THRESH_C)) begin
          state     <= REQ;
          alarm_req <= 1'b1;
        end
        REQ: if (alarm_ack) begin
          state     <= WAIT_CLR;
          alarm_req <= 1'b0;
        end
        WAIT_CLR: if (clear) state <= IDLE;
        default: begin
          state     <= IDLE;
          alarm_req <= 1'b0;
        end
      endcase
    end
  end

  // Entry storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem[wr_ptr[AW-1:0]]   <= ex_pc;
      mask_mem[wr_ptr[AW-1:0]] <= new_bits;
    end
  end

  assign rd_pc   = fifo_empty ? 32'h0 : pc_mem[rd_ptr[AW-1:0]];
  assign rd_mask = fifo_empty ? 32'h0 : mask_mem[rd_ptr[AW-1:0]];

`ifdef OR1200_ASSERT_LOG_TIMESTAMP_EN
  logic [15:0] stamp_cnt;
  logic [15:0] stamp_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) stamp_cnt <= '0;
    else     stamp_cnt <= stamp_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (do_push) stamp_mem[wr_ptr[AW-1:0]] <= stamp_cnt;
  end

  assign rd_stamp = fifo_empty ? 16'h0 : stamp_mem[rd_ptr[AW-1:0]];
`else
  assign rd_stamp = 16'h0;
`endif

endmodule

// File: tb/tb_assertion_event_logger.sv
// Directed bench for assertion_event_logger with DEPTH=8, CNT_W=16, THRESH=1.
module tb_assertion_event_logger;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] checkers_fired;
  logic [31:0] ex_pc;
  logic [31:0] chk_mask;
  logic        rd_en;
  logic        clear;
  logic        alarm_ack;
  logic [31:0] sticky;
  logic [15:0] event_count;
  logic        fifo_empty;
  logic        fifo_full;
  logic        overflow;
  logic [31:0] rd_pc;
  logic [31:0] rd_mask;
  logic [15:0] rd_stamp;
  logic        alarm_req;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assertion_event_logger #(.DEPTH(8), .CNT_W(16), .THRESH(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .checkers_fired(checkers_fired),
    .ex_pc(ex_pc), .chk_mask(chk_mask), .rd_en(rd_en), .clear(clear),
    .alarm_ack(alarm_ack), .sticky(sticky), .event_count(event_count),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .overflow(overflow),
    .rd_pc(rd_pc), .rd_mask(rd_mask), .rd_stamp(rd_stamp), .alarm_req(alarm_req)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; checkers_fired = '0; ex_pc = '0;
    chk_mask = 32'hFFFF_FFFF; rd_en = 1'b0; clear = 1'b0; alarm_ack = 1'b0;
    tick(); tick();
    chk("rst_sticky", sticky, 32'h0);
    chk("rst_count", 32'(event_count), 32'h0);
    chk("rst_empty", 32'(fifo_empty), 32'h1);
    chk("rst_full", 32'(fifo_full), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_rd_pc", rd_pc, 32'h0);
    chk("rst_rd_mask", rd_mask, 32'h0);
    chk("rst_stamp", 32'(rd_stamp), 32'h0);
    chk("rst_req", 32'(alarm_req), 32'h0);
    rst = 1'b0;

    // Bit 1 held high for three cycles logs once.
    checkers_fired = 32'h2; ex_pc = 32'h100;
    tick();
    chk("ev1_sticky", sticky, 32'h2);
    chk("ev1_count", 32'(event_count), 32'h1);
    chk("ev1_empty", 32'(fifo_empty), 32'h0);
    chk("ev1_pc", rd_pc, 32'h100);
    chk("ev1_mask", rd_mask, 32'h2);
    chk("ev1_req", 32'(alarm_req), 32'h1);
    tick(); tick();
    chk("hold_count", 32'(event_count), 32'h1);
    checkers_fired = 32'h0;
    tick();

    // Alarm handshake.
    alarm_ack = 1'b1;
    tick();
    chk("ack_req", 32'(alarm_req), 32'h0);
    alarm_ack = 1'b0; checkers_fired = 32'h10; ex_pc = 32'h140;
    tick();
    chk("wait_req", 32'(alarm_req), 32'h0);
    chk("wait_count", 32'(event_count), 32'h2);
    checkers_fired = 32'h0; clear = 1'b1;
    tick();
    chk("clr_count", 32'(event_count), 32'h0);
    chk("clr_sticky", sticky, 32'h0);
    clear = 1'b0; checkers_fired = 32'h20; ex_pc = 32'h180;
    tick();
    chk("rearm_req", 32'(alarm_req), 32'h1);
    chk("rearm_count", 32'(event_count), 32'h1);
    chk("rearm_sticky", sticky, 32'h20);
    checkers_fired = 32'h0; alarm_ack = 1'b1;
    tick();
    alarm_ack = 1'b0;

    // Drain three entries in order, then rd_en on empty is ignored.
    rd_en = 1'b1;
    chk("pop0_pc", rd_pc, 32'h100);
    tick();
    chk("pop1_pc", rd_pc, 32'h140);
    chk("pop1_mask", rd_mask, 32'h10);
    tick();
    chk("pop2_pc", rd_pc, 32'h180);
    tick();
    chk("pop3_empty", 32'(fifo_empty), 32'h1);
    chk("pop3_pc", rd_pc, 32'h0);
    tick();
    chk("pop_idle_empty", 32'(fifo_empty), 32'h1);
    rd_en = 1'b0;

    // Masked bit 1 ignored, bit 3 logged.
    clear = 1'b1;
    tick();
    clear = 1'b0; chk_mask = 32'hFFFF_FFFD; checkers_fired = 32'h2; ex_pc = 32'h1F0;
    tick();
    chk("msk_count", 32'(event_count), 32'h0);
    chk("msk_empty", 32'(fifo_empty), 32'h1);
    checkers_fired = 32'h0;
    tick();
    checkers_fired = 32'h8; ex_pc = 32'h200;
    tick();
    chk("msk_sticky", sticky, 32'h8);
    chk("msk_pc", rd_pc, 32'h200);
    chk("msk_mask", rd_mask, 32'h8);
    chk("msk_count1", 32'(event_count), 32'h1);
    checkers_fired = 32'h0; alarm_ack = 1'b1;
    tick();
    alarm_ack = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0; chk_mask = 32'hFFFF_FFFF;
    chk("msk_drain", 32'(fifo_empty), 32'h1);

    // Nine distinct events into an 8-entry FIFO.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checkers_fired = 32'h1 << i; ex_pc = 32'h1000 + 32'(i) * 4;
      tick();
      if (i == 7) begin
        chk("fill8_full", 32'(fifo_full), 32'h1);
        chk("fill8_count", 32'(event_count), 32'h8);
        chk("fill8_ovf", 32'(overflow), 32'h0);
      end
    end
    chk("fill9_ovf", 32'(overflow), 32'h1);
    chk("fill9_count", 32'(event_count), 32'h9);
    chk("fill9_full", 32'(fifo_full), 32'h1);
    chk("fill9_head", rd_pc, 32'h1000);

    // Push and pop together while full.
    checkers_fired = 32'h0010_0000; ex_pc = 32'h2000; rd_en = 1'b1;
    tick();
    chk("pp_full", 32'(fifo_full), 32'h1);
    chk("pp_head", rd_pc, 32'h1004);
    chk("pp_count", 32'(event_count), 32'd10);
    checkers_fired = 32'h0;
    for (int i = 0; i < 8; i++) begin
      chk("drain_pc", rd_pc, (i < 7) ? 32'h1004 + 32'(i) * 4 : 32'h2000);
      if (i == 7) chk("drain_tail_mask", rd_mask, 32'h0010_0000);
      tick();
    end
    chk("drain_empty", 32'(fifo_empty), 32'h1);
    rd_en = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'h0);

    // Disabled sampling.
    enable = 1'b0; checkers_fired = 32'h4;
    tick();
    chk("dis_count", 32'(event_count), 32'h0);
    chk("dis_empty", 32'(fifo_empty), 32'h1);
    enable = 1'b1; checkers_fired = 32'h0;
    tick();

    // Reset mid-operation, then stamp an event at cycle 0x10.
    checkers_fired = 32'h40; ex_pc = 32'h300;
    tick();
    chk("pre_rst_empty", 32'(fifo_empty), 32'h0);
    checkers_fired = 32'h0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_empty", 32'(fifo_empty), 32'h1);
    chk("mid_rst_count", 32'(event_count), 32'h0);
    chk("mid_rst_req", 32'(alarm_req), 32'h0);
    repeat (16) tick();
    checkers_fired = 32'h80; ex_pc = 32'h400;
    tick();
    chk("ts_pc", rd_pc, 32'h400);
`ifdef OR1200_ASSERT_LOG_TIMESTAMP_EN
    chk("ts_stamp", 32'(rd_stamp), 32'h10);
`else
    chk("ts_stamp", 32'(rd_stamp), 32'h0);
`endif
    checkers_fired = 32'h0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
